// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM states and the
// ISA function codes of the HI/LO operations it accepts.
// No ports; imported by muldiv_sequencer.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // ISA function codes (SPECIAL opcode, funct field)
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's complement of a 2*WIDTH value; combinational, no backpressure.
// Ports: value in, neg_lo/neg_hi per-half negate enables, chain=1 treats the
// value as one 2*WIDTH number (product), chain=0 negates the halves independently
// (low = quotient, high = remainder); result out.
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] value,
  input  logic               neg_lo,
  input  logic               neg_hi,
  input  logic               chain,
  output logic [2*WIDTH-1:0] result
);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W = '0;

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             hi_inc;

  assign lo = value[WIDTH-1:0];
  assign hi = value[2*WIDTH-1:WIDTH];
  // Negating the full value carries out of the low half only when it is zero.
  assign hi_inc = chain ? (lo == ZERO_W) : 1'b1;

  assign result[WIDTH-1:0]       = neg_lo ? (~lo + ONE_W) : lo;
  assign result[2*WIDTH-1:WIDTH] = neg_hi ? (~hi + (hi_inc ? ONE_W : ZERO_W)) : hi;
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer plus architectural HI/LO (MTHI/MTLO).
// Latency: WIDTH+2 cycles start-to-done for mul/div, 2 for divide-by-zero, 1 for MTHI/MTLO.
// Backpressure: w_busy_1 stalls the pipeline; starts while busy are ignored; w_flush_1 aborts.
// Optional: define MULDIV_EARLY_OUT_EN to end a multiply once the remaining multiplier is zero.
// Ports: w_clock/w_reset_n, issue (w_start_1, w_op_code_6, w_input1_x=rs, w_input2_x=rt),
// w_flush_1, status (w_busy_1, w_done_1, w_div_by_zero_1), results (w_hi_x, w_lo_x).
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             w_clock,
  input  logic             w_reset_n,
  input  logic             w_start_1,
  input  logic [5:0]       w_op_code_6,
  input  logic [WIDTH-1:0] w_input1_x,
  input  logic [WIDTH-1:0] w_input2_x,
  input  logic             w_flush_1,
  output logic             w_busy_1,
  output logic             w_done_1,
  output logic             w_div_by_zero_1,
  output logic [WIDTH-1:0] w_hi_x,
  output logic [WIDTH-1:0] w_lo_x
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  state_e             state;
  logic [2*WIDTH-1:0] acc;     // product accumulator, or {remainder, quotient}
  logic [2*WIDTH-1:0] mcand;   // shifted multiplicand; divisor in the low half
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               dbz;
  logic               neg_main;  // product / quotient sign
  logic               neg_rem;   // remainder sign (product sign for multiply)

  // Operand magnitudes and signs
  logic             op_signed;
  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  assign op_signed = (w_op_code_6 == OP_MULT) || (w_op_code_6 == OP_DIV);
  assign sign1     = op_signed & w_input1_x[WIDTH-1];
  assign sign2     = op_signed & w_input2_x[WIDTH-1];
  assign mag1      = sign1 ? (~w_input1_x + ONE_W) : w_input1_x;
  assign mag2      = sign2 ? (~w_input2_x + ONE_W) : w_input2_x;

  // One iteration of each algorithm
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;

  assign mul_next = acc + (mplier[0] ? mcand : '0);
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, mcand[WIDTH-1:0]};
  // rem_sh < 2*divisor, so bit WIDTH of the difference is a clean borrow flag.
  assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] fixed;

  muldiv_negate #(.WIDTH(WIDTH)) u_negate (
    .value  (acc),
    .neg_lo (neg_main),
    .neg_hi (neg_rem),
    .chain  (!is_div),
    .result (fixed)
  );

  logic last_iter;
`ifdef MULDIV_EARLY_OUT_EN
  assign last_iter = (cnt == CW'(1)) || (!is_div && (mplier[WIDTH-1:1] == '0));
`else
  assign last_iter = (cnt == CW'(1));
`endif

  assign w_busy_1 = (state != ST_IDLE);

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state           <= ST_IDLE;
      acc             <= '0;
      mcand           <= '0;
      mplier          <= '0;
      cnt             <= '0;
      is_div          <= 1'b0;
      dbz             <= 1'b0;
      neg_main        <= 1'b0;
      neg_rem         <= 1'b0;
      w_done_1        <= 1'b0;
      w_div_by_zero_1 <= 1'b0;
      w_hi_x          <= '0;
      w_lo_x          <= '0;
    end else begin
      w_done_1        <= 1'b0;
      w_div_by_zero_1 <= 1'b0;
      if (w_flush_1) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (w_start_1) begin
              case (w_op_code_6)
                OP_MTHI: begin
                  w_hi_x   <= w_input1_x;
                  w_done_1 <= 1'b1;
                end
                OP_MTLO: begin
                  w_lo_x   <= w_input1_x;
                  w_done_1 <= 1'b1;
                end
                OP_MULT, OP_MULTU: begin
                  acc      <= '0;
                  mcand    <= {{WIDTH{1'b0}}, mag1};
                  mplier   <= mag2;
                  cnt      <= CW'(WIDTH);
                  is_div   <= 1'b0;
                  dbz      <= 1'b0;
                  neg_main <= sign1 ^ sign2;
                  neg_rem  <= sign1 ^ sign2;
                  state    <= ST_CALC;
                end
                OP_DIV, OP_DIVU: begin
                  mcand    <= {{WIDTH{1'b0}}, mag2};
                  mplier   <= mag2;
                  cnt      <= CW'(WIDTH);
                  is_div   <= 1'b1;
                  neg_main <= sign1 ^ sign2;
                  neg_rem  <= sign1;
                  if (w_input2_x == '0) begin
                    // Keep raw rs: it becomes HI on a divide by zero.
                    acc   <= {{WIDTH{1'b0}}, w_input1_x};
                    dbz   <= 1'b1;
                    state <= ST_FIX;
                  end else begin
                    acc   <= {{WIDTH{1'b0}}, mag1};
                    dbz   <= 1'b0;
                    state <= ST_CALC;
                  end
                end
                default: ;
              endcase
            end
          end
          ST_CALC: begin
            if (is_div) begin
              acc <= div_next;
            end else begin
              acc    <= mul_next;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
            cnt <= cnt - CW'(1);
            if (last_iter) state <= ST_FIX;
          end
          ST_FIX: begin
            if (dbz) begin
              w_hi_x          <= acc[WIDTH-1:0];
              w_lo_x          <= '1;
              w_div_by_zero_1 <= 1'b1;
            end else begin
              w_hi_x <= fixed[2*WIDTH-1:WIDTH];
              w_lo_x <= fixed[WIDTH-1:0];
            end
            w_done_1 <= 1'b1;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for multiply/divide and the architectural HI/LO register pair. Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation from the execute stage, runs a one-bit-per-cycle shift-add multiply or restoring divide, and commits HI/LO on completion. Raises a stall (`w_busy_1`) so the pipeline holds MFHI/MFLO and further HI/LO operations while a computation is in flight. Sits beside the ALU in execute; the ALU keeps single-cycle ops and reads HI/LO from this block.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `w_clock` in 1: clock, rising edge.
- `w_reset_n` in 1: asynchronous, active-low reset.
- `w_start_1` in 1: issue strobe, sampled at rising edge.
- `w_op_code_6` in 6: shared ISA function code for MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `w_input1_x` in WIDTH: rs (multiplicand/dividend; MTHI/MTLO source).
- `w_input2_x` in WIDTH: rt (multiplier/divisor).
- `w_flush_1` in 1: abort in-flight operation.
- `w_busy_1` out 1: high whenever state ≠ IDLE.
- `w_done_1` out 1: one-cycle completion pulse.
- `w_div_by_zero_1` out 1: one-cycle pulse coincident with `w_done_1` for DIV/DIVU with rt = 0.
- `w_hi_x` out WIDTH: architectural HI.
- `w_lo_x` out WIDTH: architectural LO.

## Operation
- Reset: state IDLE, HI = LO = 0, `w_busy_1` = `w_done_1` = `w_div_by_zero_1` = 0. Reset mid-operation discards all work.
- States: IDLE, CALC, FIX.
- IDLE + start + MULT/MULTU/DIV/DIVU: latch magnitudes (signed ops take abs; unsigned use raw values) and the result sign flags, counter = WIDTH, go to CALC. If divide and rt = 0, go directly to FIX.
- IDLE + start + MTHI/MTLO: write HI or LO from rs at that edge; `w_done_1` next cycle; stays IDLE, never busy.
- IDLE + start + any other code: ignored, no done.
- Start while not IDLE: ignored. The pipeline must not issue while busy.
- CALC multiply: if multiplier LSB is set, add the shifted multiplicand into the 2·WIDTH accumulator; shift the multiplicand left and the multiplier right; decrement the counter.
- CALC divide: restoring step; shift the remainder:quotient left, trial-subtract the divisor, keep the result if it is non-negative and set the quotient bit.
- CALC → FIX when the counter reaches 0 after an iteration.
- FIX: apply sign correction, write HI/LO, pulse done, go to IDLE.
  - Signed multiply: negate the 2·WIDTH product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
  - Divide by zero: HI = rs, LO = all ones, `w_div_by_zero_1` = 1.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the magnitude path with no special casing.
- `w_flush_1`: any state → IDLE at the next edge; HI/LO unchanged; no done. Flush wins over a same-cycle start and over the FIX commit.

## Timing
- Start sampled at edge 0.
- Multiply/divide: CALC iterations occupy edges 1..WIDTH, FIX is edge WIDTH+1.
- `w_busy_1` is high in cycles 1..WIDTH+1. `w_done_1` and the new HI/LO are visible in cycle WIDTH+2 (cycle 34 for WIDTH = 32).
- Divide by zero: busy in cycle 1 only; done in cycle 2.
- MTHI/MTLO: HI/LO update visible in cycle 1; done in cycle 1.
- A new start is accepted in the done cycle (back-to-back).
- HI/LO hold their old values throughout CALC.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: in CALC multiply, go to FIX after any iteration that leaves the shifted multiplier at zero. Example: multiply by 0 or 1 gives busy for cycles 1..2 and done in cycle 3. Divide is unaffected.
- Not defined: every multiply takes exactly WIDTH iterations.

## Structure
- The shared package holds the state encodings (IDLE, CALC, FIX). It already defines MULT/MULTU/DIV/DIVU/MTHI/MTLO; no new opcode constants are added.
- Sub-module `muldiv_negate`: conditional two's-complement of a `2*WIDTH` value. It is used in FIX for the product, and its low/high halves serve the quotient and remainder.

## Test plan
- MULT 0xFFFFFFFE × 3: done in cycle 34, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. Busy is high in cycles 1..33 and low elsewhere.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV −7 / 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 0: done in cycle 2, `w_div_by_zero_1` = 1, HI = 7, LO = 0xFFFFFFFF.
- MTHI 0x12345678, then MULT issued in its done cycle: HI reads 0x12345678 until the multiply's done cycle, then shows the product.
- Flush in cycle 10 of a DIV: IDLE in cycle 11, no done, HI/LO unchanged. A start presented in the flush cycle is ignored.
- Reset asserted in cycle 5 of a MULT: all outputs go to 0 immediately. With `MULDIV_EARLY_OUT_EN` defined, MULT 5 × 1 completes in cycle 3 with LO = 5.
